mem_access: RTL and testbench

// - MEM pipeline stage between ex_mem and mem_wb of the 5-stage RV32I core.
// - Performs LB/LH/LW/LBU/LHU/SB/SH/SW over the byte-wide memory-controller port, one byte per handshake.
// - Stalls the pipeline while the access is in flight.
// - Drives rd_data/rd_addr/rd_enable into mem_wb; non-memory instructions pass through with zero latency.

---
 rtl/mem_access_pkg.sv | 33 +++
 rtl/mem_load_ext.sv | 18 +
 rtl/mem_access.sv | 90 +++++++++
 tb/tb_mem_access.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: memory-op codes, FSM state encodings and op decode helpers
// shared by the MEM stage and its load extender.
package mem_access_pkg;

  localparam logic [3:0] MEM_NONE = 4'd0;
  localparam logic [3:0] MEM_LB   = 4'd1;
  localparam logic [3:0] MEM_LH   = 4'd2;
  localparam logic [3:0] MEM_LW   = 4'd3;
  localparam logic [3:0] MEM_LBU  = 4'd4;
  localparam logic [3:0] MEM_LHU  = 4'd5;
  localparam logic [3:0] MEM_SB   = 4'd6;
  localparam logic [3:0] MEM_SH   = 4'd7;
  localparam logic [3:0] MEM_SW   = 4'd8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  function automatic logic is_mem(input logic [3:0] op);
    return op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW};
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return op inside {MEM_SB, MEM_SH, MEM_SW};
  endfunction

  // Index of the final byte of an access: N-1.
  function automatic logic [1:0] last_idx(input logic [3:0] op);
    return (op inside {MEM_LB, MEM_LBU, MEM_SB}) ? 2'd0 :
           (op inside {MEM_LH, MEM_LHU, MEM_SH}) ? 2'd1 : 2'd3;
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// mem_load_ext: sign/zero-extends the assembled load buffer according to the
// load width and signedness of the op.
module mem_load_ext
  import mem_access_pkg::*;
(
  input  logic [31:0] buf_i,
  input  logic [3:0]  op_i,
  output logic [31:0] res_o
);

  always_comb begin
    res_o = (op_i == MEM_LB)  ? {{24{buf_i[7]}},  buf_i[7:0]}  :
            (op_i == MEM_LH)  ? {{16{buf_i[15]}}, buf_i[15:0]} :
            (op_i == MEM_LBU) ? {24'd0, buf_i[7:0]}            :
            (op_i == MEM_LHU) ? {16'd0, buf_i[15:0]}           : buf_i;
  end

endmodule

// File: rtl/mem_access.sv
// mem_access: MEM pipeline stage; serialises loads/stores into byte handshakes
// with the memory controller and stalls the pipeline while they are in flight.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [XLEN-1:0]    rd_data_i,
  input  logic [RADDR_W-1:0] rd_addr_i,
  input  logic               rd_enable_i,
  input  logic [3:0]         mem_op_i,
  input  logic [XLEN-1:0]    mem_addr_i,
  input  logic [XLEN-1:0]    mem_wdata_i,
  output logic               mem_req_o,
  output logic               mem_we_o,
  output logic [XLEN-1:0]    mem_a_o,
  output logic [7:0]         mem_dout_o,
  input  logic [7:0]         mem_din_i,
  input  logic               mem_ack_i,
  output logic [XLEN-1:0]    rd_data_o,
  output logic [RADDR_W-1:0] rd_addr_o,
  output logic               rd_enable_o,
  output logic               stall_req_o
);

  logic [1:0]  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] ld_buf_q, ld_buf_d;
  logic [31:0] ld_ext;
  logic        mem_op, store, idle, xfer, done, wb_pass, wb_done;

  assign mem_op = is_mem(mem_op_i);
  assign store  = is_store(mem_op_i);
  assign idle   = state_q == S_IDLE;
  assign xfer   = state_q == S_XFER;
  assign done   = state_q == S_DONE;

  mem_load_ext u_ext (
    .buf_i (ld_buf_q),
    .op_i  (mem_op_i),
    .res_o (ld_ext)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ld_buf_d = ld_buf_q;
    if (idle && mem_op) begin
      state_d  = S_XFER;
      cnt_d    = 2'd0;
      ld_buf_d = 32'd0;
    end else if (xfer && mem_ack_i) begin
      if (!store) ld_buf_d[{cnt_q, 3'b000} +: 8] = mem_din_i;
      state_d = (cnt_q == last_idx(mem_op_i)) ? S_DONE : S_XFER;
      cnt_d   = (cnt_q == last_idx(mem_op_i)) ? 2'd0 : cnt_q + 2'd1;
    end else if (!idle && !xfer) begin
      state_d = S_IDLE;
      cnt_d   = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 2'd0;
      ld_buf_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ld_buf_q <= ld_buf_d;
    end
  end

  // Every output is gated by rst so nothing leaks out while reset is held.
  assign wb_pass     = rst && idle && !mem_op;
  assign wb_done     = rst && done;
  assign mem_req_o   = rst && xfer;
  assign mem_we_o    = rst && xfer && store;
  assign mem_a_o     = (rst && xfer) ? mem_addr_i + XLEN'(cnt_q) : '0;
  assign mem_dout_o  = (rst && xfer) ? mem_wdata_i[{cnt_q, 3'b000} +: 8] : 8'd0;
  assign stall_req_o = rst && ((idle && mem_op) || xfer);
  assign rd_enable_o = (wb_pass || wb_done) && rd_enable_i;
  assign rd_addr_o   = (wb_pass || wb_done) ? rd_addr_i : '0;
  assign rd_data_o   = (wb_pass || (wb_done && (store || !mem_op))) ? rd_data_i :
                       wb_done ? XLEN'(ld_ext) : '0;

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: scoreboard bench; a byte responder plays the memory controller
// and a writeback monitor retires one instruction per unstalled cycle.
module tb_mem_access;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] rd_data_i, mem_addr_i, mem_wdata_i, mem_a_o, rd_data_o;
  logic [4:0]  rd_addr_i, rd_addr_o;
  logic        rd_enable_i, mem_req_o, mem_we_o, mem_ack_i, rd_enable_o, stall_req_o;
  logic [3:0]  mem_op_i;
  logic [7:0]  mem_dout_o, mem_din_i;

  mem_access #(.XLEN(32), .RADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .rd_data_i(rd_data_i), .rd_addr_i(rd_addr_i), .rd_enable_i(rd_enable_i),
    .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_a_o(mem_a_o),
    .mem_dout_o(mem_dout_o), .mem_din_i(mem_din_i), .mem_ack_i(mem_ack_i),
    .rd_data_o(rd_data_o), .rd_addr_o(rd_addr_o), .rd_enable_o(rd_enable_o),
    .stall_req_o(stall_req_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic        we;
    logic [7:0]  d;
    int          dly;
  } bx_t;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  a;
    logic        en;
    int          stall;
  } wb_t;

  bx_t bq[$];
  wb_t wbq[$];
  bx_t cur;
  int  checks = 0;
  int  failures = 0;
  int  rw = -1;
  bit  active = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [3:0] op);
    if (op inside {MEM_LB, MEM_LBU, MEM_SB}) return 1;
    if (op inside {MEM_LH, MEM_LHU, MEM_SH}) return 2;
    if (op inside {MEM_LW, MEM_SW}) return 4;
    return 0;
  endfunction

  // Reference model: byte list in address order plus the architectural writeback value.
  task automatic start(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] ld, input logic [31:0] rdd, input logic [4:0] rda,
                       input logic en, input int dly);
    int     n = nbytes(op);
    int     st = 0;
    bit     store = op inside {MEM_SB, MEM_SH, MEM_SW};
    bit     sgn = op inside {MEM_LB, MEM_LH};
    longint v;
    bx_t    b;
    wb_t    w;
    for (int k = 0; k < n; k++) begin
      b.a   = addr + k;
      b.we  = store;
      b.d   = store ? wdata[8*k +: 8] : ld[8*k +: 8];
      b.dly = (dly < 0) ? int'($urandom_range(2, 0)) : dly;
      st += b.dly + 1;
      bq.push_back(b);
    end
    v = (n == 0) ? 0 : longint'(ld) % (longint'(1) << (8 * n));
    if (sgn && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
    w.d     = (n == 0 || store) ? rdd : v[31:0];
    w.a     = rda;
    w.en    = en;
    w.stall = (n == 0) ? 0 : st + 1;
    wbq.push_back(w);
    mem_op_i    = op;
    mem_addr_i  = addr;
    mem_wdata_i = wdata;
    rd_data_i   = rdd;
    rd_addr_i   = rda;
    rd_enable_i = en;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] ld, input logic [31:0] rdd, input logic [4:0] rda,
                       input logic en, input int dly);
    bit ok = 1'b0;
    start(op, addr, wdata, ld, rdd, rda, en, dly);
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (!stall_req_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      failures++;
      $display("FAIL timeout: op %0d never left stall", op);
    end
    @(posedge clk);
    #1;
  endtask

  // Memory controller model: acks each requested byte after its chosen delay.
  initial begin
    mem_ack_i = 1'b0;
    mem_din_i = 8'd0;
    forever begin
      @(negedge clk);
      if (rst && mem_req_o) begin
        if (rw < 0) begin
          if (bq.size() == 0) begin
            failures++;
            $display("FAIL byte_req: unexpected request addr %h", mem_a_o);
          end else begin
            cur = bq.pop_front();
            rw  = cur.dly;
          end
        end
        if (rw == 0) begin
          chk("byte_addr", mem_a_o, cur.a);
          chk("byte_we", {31'd0, mem_we_o}, {31'd0, cur.we});
          if (cur.we) chk("byte_dout", {24'd0, mem_dout_o}, {24'd0, cur.d});
          chk("xfer_stall", {31'd0, stall_req_o}, 32'd1);
          chk("xfer_rd_en", {31'd0, rd_enable_o}, 32'd0);
          mem_din_i = cur.we ? 8'($urandom) : cur.d;
          mem_ack_i = 1'b1;
          rw = -1;
          @(posedge clk);
          #1 mem_ack_i = 1'b0;
        end else if (rw > 0) begin
          rw--;
        end
      end
    end
  end

  // Writeback monitor: each unstalled cycle retires the oldest expected instruction.
  initial begin
    int  sc = 0;
    wb_t w;
    forever begin
      @(negedge clk);
      if (!rst) sc = 0;
      else if (stall_req_o) sc++;
      else begin
        if (active) begin
          if (wbq.size() == 0) begin
            failures++;
            $display("FAIL wb_unexpected: rd_data_o %h", rd_data_o);
          end else begin
            w = wbq.pop_front();
            chk("wb_data", rd_data_o, w.d);
            chk("wb_addr", {27'd0, rd_addr_o}, {27'd0, w.a});
            chk("wb_en", {31'd0, rd_enable_o}, {31'd0, w.en});
            chk("stall_cycles", sc, w.stall);
          end
        end
        sc = 0;
      end
    end
  end

  initial begin
    mem_op_i    = MEM_NONE;
    mem_addr_i  = 32'h55;
    mem_wdata_i = 32'h0;
    rd_data_i   = 32'hDEADBEEF;
    rd_addr_i   = 5'd7;
    rd_enable_i = 1'b1;
    #12;
    chk("rst_rd_data", rd_data_o, 32'd0);
    chk("rst_rd_en", {31'd0, rd_enable_o}, 32'd0);
    chk("rst_rd_addr", {27'd0, rd_addr_o}, 32'd0);
    chk("rst_stall", {31'd0, stall_req_o}, 32'd0);
    chk("rst_req", {31'd0, mem_req_o}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    active = 1'b1;
    issue(MEM_NONE, 32'h0, 32'h0, 32'h0, 32'h1234, 5'd5, 1'b1, 0);
    issue(MEM_LW, 32'h100, 32'h0, 32'h80332211, 32'h9999, 5'd3, 1'b1, 0);
    issue(MEM_LB, 32'h7, 32'h0, 32'h5A5A5AF0, 32'h0, 5'd10, 1'b1, 0);
    issue(MEM_LBU, 32'h7, 32'h0, 32'hA5A5A5F0, 32'h0, 5'd11, 1'b1, 1);
    issue(MEM_LH, 32'h40, 32'h0, 32'h77779234, 32'h0, 5'd12, 1'b1, 0);
    issue(MEM_LHU, 32'h41, 32'h0, 32'h88889234, 32'h0, 5'd13, 1'b1, 2);
    issue(MEM_SH, 32'h201, 32'hAABBCCDD, 32'h0, 32'h4444, 5'd0, 1'b0, 3);
    issue(MEM_SB, 32'hFFFFFFFF, 32'h123456EE, 32'h0, 32'h5555, 5'd1, 1'b1, 0);
    issue(MEM_SW, 32'h1FE, 32'h01020304, 32'h0, 32'h6666, 5'd2, 1'b1, 1);
    repeat (150)
      issue(4'($urandom_range(8, 0)), $urandom, $urandom, $urandom, $urandom,
            5'($urandom_range(31, 0)), 1'($urandom_range(1, 0)), -1);
    // Reset in the middle of a LW, after its second byte has been acked.
    start(MEM_LW, 32'h300, 32'h0, 32'hCAFEF00D, 32'h0, 5'd9, 1'b1, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("midrst_req", {31'd0, mem_req_o}, 32'd0);
    chk("midrst_stall", {31'd0, stall_req_o}, 32'd0);
    chk("midrst_rd_en", {31'd0, rd_enable_o}, 32'd0);
    active = 1'b0;
    bq.delete();
    wbq.delete();
    rw = -1;
    mem_op_i    = MEM_NONE;
    rd_data_i   = 32'hFEEDFACE;
    rd_enable_i = 1'b1;
    @(negedge clk);
    chk("held_rst_data", rd_data_o, 32'd0);
    chk("held_rst_en", {31'd0, rd_enable_o}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    active = 1'b1;
    issue(MEM_LW, 32'h300, 32'h0, 32'h12345678, 32'h0, 5'd9, 1'b1, 0);
    issue(MEM_LB, 32'h300, 32'h0, 32'hFFFFFF7F, 32'h0, 5'd8, 1'b1, 0);
    issue(MEM_LHU, 32'h302, 32'h0, 32'h0000ABCD, 32'h0, 5'd4, 1'b1, 1);
    active = 1'b0;
    chk("bytes_drained", bq.size(), 32'd0);
    chk("wb_drained", wbq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
